// File: rtl/serial_subtractor.sv
// Purpose : bit-serial A - B - Bin, BPC bits per clock, LSB chunk first, borrow carried in a register.
// Latency : N = WIDTH/BPC cycles from accept to out_valid; one op per N+2 cycles at best.
// Backpressure: result (Diff/Bout/Ovf) held with out_valid high while out_ready is low; in_ready low while busy.
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid / in_ready   - operand handshake (in_ready high only in IDLE)
//   A, B, Bin             - minuend, subtrahend, borrow-in (WIDTH, WIDTH, 1)
//   out_valid / out_ready - result handshake (out_valid high only in DONE)
//   Diff, Bout            - (A - B - Bin) mod 2^WIDTH, final borrow
//   Ovf                   - signed overflow, only when SUB_OVF_EN is defined
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
`ifdef SUB_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (WIDTH < 1 || (WIDTH % BPC) != 0) begin : g_bad_cfg
      $error("serial_subtractor: WIDTH must be >= 1 and a multiple of BPC");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  // Operands and result kept as chunk arrays so the per-cycle select is a
  // plain N-way mux indexed by the counter.
  logic [N-1:0][BPC-1:0] a_q;
  logic [N-1:0][BPC-1:0] b_q;
  logic [N-1:0][BPC-1:0] diff_q;
  logic [CW-1:0]         cnt;
  logic                  brw;
  logic                  bout_q;

  logic [BPC-1:0] a_c;
  logic [BPC-1:0] b_c;
  logic [BPC-1:0] d_c;
  logic           b_nxt;

  // One BPC-bit subtract per cycle; the extra top bit of the BPC+1 result
  // is the borrow out of this chunk.
  always_comb begin
    a_c = a_q[cnt];
    b_c = b_q[cnt];
    {b_nxt, d_c} = {1'b0, a_c} - {1'b0, b_c} - {{BPC{1'b0}}, brw};
  end

`ifdef SUB_OVF_EN
  logic ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      brw    <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
`ifdef SUB_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= A;
            b_q   <= B;
            brw   <= Bin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          diff_q[cnt] <= d_c;
          brw         <= b_nxt;
          cnt         <= cnt + 1'b1;
          if (cnt == LAST) begin
            bout_q <= b_nxt;
            state  <= DONE;
`ifdef SUB_OVF_EN
            // The last chunk holds the MSB, so d_c[BPC-1] is the final Diff MSB.
            ovf_q  <= (a_q[N-1][BPC-1] != b_q[N-1][BPC-1]) &&
                      (d_c[BPC-1] != a_q[N-1][BPC-1]);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake flags decode straight from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign Diff      = diff_q;
  assign Bout      = bout_q;
`ifdef SUB_OVF_EN
  assign Ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: three instances (8/1, 8/4, 16/8) with a
// queue-based scoreboard per instance and an arithmetic reference model.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        iv[3];
  logic        ordy[3];
  logic        bi[3];
  logic [15:0] av[3];
  logic [15:0] bv[3];

  logic [7:0]  d0, d1;
  logic [15:0] d2;
  logic        ir0, ir1, ir2, ov0, ov1, ov2, bo0, bo1, bo2;
`ifdef SUB_OVF_EN
  logic        of0, of1, of2;
`endif

  logic        irA[3], ovA[3], boA[3], ofA[3];
  logic [15:0] dA[3];

  always_comb begin
    irA[0] = ir0; irA[1] = ir1; irA[2] = ir2;
    ovA[0] = ov0; ovA[1] = ov1; ovA[2] = ov2;
    boA[0] = bo0; boA[1] = bo1; boA[2] = bo2;
    dA[0]  = {8'h00, d0};
    dA[1]  = {8'h00, d1};
    dA[2]  = d2;
`ifdef SUB_OVF_EN
    ofA[0] = of0; ofA[1] = of1; ofA[2] = of2;
`else
    ofA[0] = 1'b0; ofA[1] = 1'b0; ofA[2] = 1'b0;
`endif
  end

  serial_subtractor #(.WIDTH(8), .BPC(1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0),
    .A(av[0][7:0]), .B(bv[0][7:0]), .Bin(bi[0]),
    .out_valid(ov0), .out_ready(ordy[0]), .Diff(d0), .Bout(bo0)
`ifdef SUB_OVF_EN
    , .Ovf(of0)
`endif
  );

  serial_subtractor #(.WIDTH(8), .BPC(4)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1),
    .A(av[1][7:0]), .B(bv[1][7:0]), .Bin(bi[1]),
    .out_valid(ov1), .out_ready(ordy[1]), .Diff(d1), .Bout(bo1)
`ifdef SUB_OVF_EN
    , .Ovf(of1)
`endif
  );

  serial_subtractor #(.WIDTH(16), .BPC(8)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir2),
    .A(av[2]), .B(bv[2]), .Bin(bi[2]),
    .out_valid(ov2), .out_ready(ordy[2]), .Diff(d2), .Bout(bo2)
`ifdef SUB_OVF_EN
    , .Ovf(of2)
`endif
  );

  int checks = 0;
  int failures = 0;
  bit bp[3];
  bit rmode = 1'b0;

  typedef struct {
    logic [15:0] d;
    logic        bo;
    logic        of;
    int          acc;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];

  function automatic int wof(int k);
    return (k == 2) ? 16 : 8;
  endfunction

  function automatic int nof(int k);
    return (k == 0) ? 8 : 2;
  endfunction

  function automatic logic [15:0] mask(int k);
    return (k == 2) ? 16'hFFFF : 16'h00FF;
  endfunction

  // Reference: plain integer arithmetic on the whole operands.
  function automatic exp_t model(int k, logic [15:0] a, logic [15:0] b, logic bn);
    exp_t   e;
    longint ai = a;
    longint bi_ = b;
    longint m  = longint'(1) << wof(k);
    longint r  = ai - bi_ - longint'(bn);
    e.d   = 16'(((r % m) + m) % m);
    e.bo  = (ai < bi_ + longint'(bn));
    e.of  = (a[wof(k)-1] != b[wof(k)-1]) && (e.d[wof(k)-1] != a[wof(k)-1]);
    e.acc = 0;
    return e;
  endfunction

  function automatic int qsize(int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void push(int k, exp_t e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic exp_t pop(int k);
    case (k)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Offers one operand set; while the DUT is busy, junk operands are shown
  // with in_valid high so any premature sampling corrupts the result.
  task automatic issue(int k, logic [15:0] a, logic [15:0] b, logic bn);
    int   n = 0;
    bit   done = 1'b0;
    exp_t e;
    a = a & mask(k);
    b = b & mask(k);
    e = model(k, a, b, bn);
    while (!done) begin
      @(negedge clk);
      if (n > 300) begin
        checks++;
        failures++;
        $display("FAIL issue_timeout u%0d in_ready never seen", k);
        iv[k] = 1'b0;
        return;
      end
      n++;
      if (irA[k]) begin
        av[k] = a; bv[k] = b; bi[k] = bn; iv[k] = 1'b1;
        done = 1'b1;
      end else begin
        iv[k] = 1'b1;
        av[k] = 16'($urandom); bv[k] = 16'($urandom); bi[k] = 1'($urandom);
      end
    end
    @(negedge clk);
    e.acc = cyc;
    push(k, e);
    chk($sformatf("u%0d_in_ready_after_accept", k), 32'(irA[k]), 32'd0);
    iv[k] = 1'b0;
    av[k] = 16'($urandom); bv[k] = 16'($urandom); bi[k] = 1'($urandom);
  endtask

  task automatic wait_idle(int k);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(irA[k] && !ovA[k] && qsize(k) == 0) && n < 200);
    chk($sformatf("u%0d_drain", k), 32'(qsize(k)), 32'd0);
  endtask

  task automatic mon(int k);
    bit   held = 1'b0;
    bit   ei = 1'b0;
    exp_t e;
    e.d = '0; e.bo = 1'b0; e.of = 1'b0; e.acc = 0;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        held = 1'b0;
        ei   = 1'b0;
      end else if (ovA[k]) begin
        if (ei) begin
          chk($sformatf("u%0d_out_valid_after_handshake", k), 32'(ovA[k]), 32'd0);
          ei = 1'b0;
        end
        chk($sformatf("u%0d_in_ready_in_done", k), 32'(irA[k]), 32'd0);
        if (!held) begin
          if (qsize(k) == 0) begin
            chk($sformatf("u%0d_unexpected_result", k), 32'(qsize(k)), 32'd1);
          end else begin
            e = pop(k);
            chk($sformatf("u%0d_diff", k), 32'(dA[k] & mask(k)), 32'(e.d));
            chk($sformatf("u%0d_bout", k), 32'(boA[k]), 32'(e.bo));
`ifdef SUB_OVF_EN
            chk($sformatf("u%0d_ovf", k), 32'(ofA[k]), 32'(e.of));
`endif
            chk($sformatf("u%0d_latency", k), 32'(cyc - e.acc), 32'(nof(k)));
          end
          held = 1'b1;
        end else begin
          chk($sformatf("u%0d_diff_hold", k), 32'(dA[k] & mask(k)), 32'(e.d));
          chk($sformatf("u%0d_bout_hold", k), 32'(boA[k]), 32'(e.bo));
        end
        if (ordy[k]) begin
          ei   = 1'b1;
          held = 1'b0;
        end
      end else begin
        if (ei) begin
          chk($sformatf("u%0d_idle_after_handshake", k), 32'(irA[k]), 32'd1);
          chk($sformatf("u%0d_diff_after_handshake", k), 32'(dA[k] & mask(k)), 32'(e.d));
          ei = 1'b0;
        end
        held = 1'b0;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) ordy[k] = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++)
        ordy[k] = bp[k] ? 1'b0 : (rmode ? 1'($urandom % 2) : 1'b1);
    end
  end

  initial fork
    mon(0);
    mon(1);
    mon(2);
  join_none

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] rnd(int k);
    case ($urandom % 6)
      0: return 16'h0000;
      1: return mask(k);
      2: return (k == 2) ? 16'h8000 : 16'h0080;
      default: return 16'($urandom) & mask(k);
    endcase
  endfunction

  initial begin
    logic [15:0] ra, rb;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; av[k] = '0; bv[k] = '0; bi[k] = 1'b0; bp[k] = 1'b0;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d_rst_out_valid", k), 32'(ovA[k]), 32'd0);
      chk($sformatf("u%0d_rst_diff", k), 32'(dA[k] & mask(k)), 32'd0);
      chk($sformatf("u%0d_rst_bout", k), 32'(boA[k]), 32'd0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("u%0d_in_ready_after_reset", k), 32'(irA[k]), 32'd1);

    // Directed vectors
    issue(0, 16'h35, 16'h12, 1'b0);
    issue(0, 16'h00, 16'h01, 1'b0);
    issue(0, 16'h05, 16'h05, 1'b1);
    issue(0, 16'h80, 16'h01, 1'b0);
    issue(0, 16'h7F, 16'hFF, 1'b0);
    issue(1, 16'hA3, 16'h3C, 1'b1);
    issue(2, 16'h0000, 16'h0000, 1'b1);
    for (int k = 0; k < 3; k++) wait_idle(k);

    // Randomized operands with random output backpressure
    rmode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 40; i++) begin
        ra = rnd(k);
        rb = rnd(k);
        issue(k, ra, rb, 1'($urandom));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_idle(k);
    end
    rmode = 1'b0;

    // Held result under 5 cycles of backpressure, junk operands ignored
    bp[0] = 1'b1;
    issue(0, 16'h35, 16'h12, 1'b0);
    begin
      int n = 0;
      do begin
        @(negedge clk); #1;
        n++;
      end while (!ov0 && n < 50);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iv[0] = 1'b1; av[0] = 16'($urandom); bv[0] = 16'($urandom); bi[0] = 1'($urandom);
      #1;
      chk("bp_out_valid", 32'(ov0), 32'd1);
      chk("bp_diff", 32'(d0), 32'h23);
      chk("bp_bout", 32'(bo0), 32'd0);
      chk("bp_in_ready", 32'(ir0), 32'd0);
    end
    iv[0] = 1'b0;
    bp[0] = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("bp_release_out_valid", 32'(ov0), 32'd0);
    chk("bp_release_in_ready", 32'(ir0), 32'd1);
    chk("bp_release_diff", 32'(d0), 32'h23);
    wait_idle(0);

    // Reset on the 4th RUN cycle aborts the operation
    issue(0, 16'hC3, 16'h5A, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(ov0), 32'd0);
    chk("abort_diff", 32'(d0), 32'd0);
    chk("abort_bout", 32'(bo0), 32'd0);
`ifdef SUB_OVF_EN
    chk("abort_ovf", 32'(of0), 32'd0);
`endif
    q0.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_in_ready", 32'(ir0), 32'd1);
    issue(0, 16'h10, 16'h01, 1'b0);
    for (int k = 0; k < 3; k++) wait_idle(k);
    chk("post_abort_diff", 32'(d0), 32'h0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Multi-cycle, parametrised subtractor that computes `A - B - Bin` over WIDTH-bit operands, `BPC` bits per clock, LSB chunk first. The borrow is carried between chunks in a register. It generalises the single-bit full-subtraction cell to any width and extends it with a valid/ready handshake, output hold under backpressure and an optional signed-overflow flag. It sits in the datapath wherever area matters more than latency.

## Interface
- `WIDTH`, 8: operand and result width in bits; must be ≥ 1.
- `BPC`, 1: bits processed per cycle. `WIDTH % BPC != 0` is an elaboration error.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: operands present.
- `in_ready` output 1: block can accept operands.
- `A` input WIDTH: minuend, unsigned, or two's complement for `Ovf`.
- `B` input WIDTH: subtrahend.
- `Bin` input 1: borrow-in.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts result.
- `Diff` output WIDTH: `(A - B - Bin) mod 2^WIDTH`.
- `Bout` output 1: final borrow; 1 iff `A < B + Bin` (unsigned).
- `Ovf` output 1: signed overflow. Present only with `SUB_OVF_EN`.

## Operation
- `N = WIDTH/BPC` chunks. Chunk counter is `max(1,$clog2(N))` bits.
- States:
  - IDLE: `in_ready=1`.
  - RUN: processes chunks.
  - DONE: `out_valid=1`.
- IDLE → RUN on `in_valid & in_ready`. On that edge, latch A and B into shift registers, load borrow register ← `Bin`, and set counter ← 0.
- RUN, each edge:
  - chunk `c` (bits `[c*BPC +: BPC]`): `{b, d} = A_c - B_c - borrow`, computed at BPC+1 bits.
  - store `d` into the Diff register at chunk position `c`; borrow ← `b`.
  - counter increments.
- RUN → DONE after chunk `N-1`. On that edge, `Bout` ← final borrow.
- DONE → IDLE on `out_ready`. `out_valid` deasserts on that edge.
- `in_ready` is low in RUN and DONE. `in_valid` there is ignored and A, B and Bin are not sampled.
- `Diff`, `Bout` and `Ovf` are registered. They stay stable from DONE entry until the next accepted operand set, including after the output handshake.
- Diff and Bout bit positions not yet computed during RUN are don't-care. Only values qualified by `out_valid` are defined.
- Reset values (async, `rst_n=0`):
  - state IDLE, counter 0, borrow 0.
  - `Diff=0`, `Bout=0`, `Ovf=0`, `out_valid=0`.
  - `in_ready=1` once `rst_n` is high.
- Reset asserted mid-RUN or in DONE aborts the operation. No result is produced; outputs take their reset values immediately.
- `in_valid` and `out_ready` may be high in the same cycle. Only the one relevant to the current state has effect. There is no IDLE/DONE overlap and no same-cycle re-accept.
- Combinational logic per cycle is BPC bits wide; no WIDTH-wide adder.

## Timing
- Accept on edge E0. Chunk `k` processed on edge E(k+1). `out_valid` rises after edge EN, i.e. latency N cycles.
- Throughput: one operation per N+2 cycles at best (accept, N RUN cycles, DONE with `out_ready=1`).
- `in_ready` and `out_valid` are decoded directly from the state register, with no combinational path from inputs.
- `out_valid` stays high indefinitely while `out_ready=0`.

## Configuration
- `SUB_OVF_EN` defined:
  - `Ovf` port and register exist.
  - At the DONE transition, `Ovf ← (A[W-1] != B[W-1]) & (Diff[W-1] != A[W-1])`, using latched operand MSBs and the final Diff MSB. Bin is included in Diff.
  - Held like Diff; reset 0.
- `SUB_OVF_EN` undefined: no `Ovf` port and no related logic. All other behaviour is identical.

## Test plan
- WIDTH=8, BPC=1: A=0x35, B=0x12, Bin=0 → after 8 cycles `out_valid=1`, `Diff=0x23`, `Bout=0`, `Ovf=0`.
- A=0x00, B=0x01, Bin=0 → `Diff=0xFF`, `Bout=1`. A=0x05, B=0x05, Bin=1 → `Diff=0xFF`, `Bout=1`.
- With `SUB_OVF_EN`: A=0x80, B=0x01, Bin=0 → `Diff=0x7F`, `Ovf=1`, `Bout=0`. A=0x7F, B=0xFF → `Diff=0x80`, `Ovf=1`, `Bout=1`.
- Backpressure: hold `out_ready=0` for 5 cycles after DONE → `out_valid`, `Diff` and `Bout` are stable and `in_ready=0`. A new operand offered with `in_valid=1` is ignored. After `out_ready=1`, IDLE is reached one cycle later.
- Reset: assert `rst_n=0` on the 4th RUN cycle → all outputs 0 immediately. After release, `in_ready=1`, and the next op A=0x10, B=0x01 yields `Diff=0x0F`.
- WIDTH=8, BPC=4: A=0xA3, B=0x3C, Bin=1 → `out_valid` after 2 cycles, `Diff=0x66`, `Bout=0`. WIDTH=16, BPC=8: A=0x0000, B=0x0000, Bin=1 → `Diff=0xFFFF`, `Bout=1`.
